// File: rtl/icache_direct_if.sv
// Fetch-side and refill-side handshake bundle for icache_direct.
// slave = cache side, master = fetcher/memory side.
interface icache_direct_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic        mem_instr_signal;
    logic [31:0] mem_instr_a;
    logic [63:0] mem_instr_d;
    logic        mem_instr_done;

    modport slave (
        input  fetch_valid, fetch_pc, mem_instr_d, mem_instr_done,
        output fetch_ready, fetch_instr, mem_instr_signal, mem_instr_a
    );

    modport master (
        output fetch_valid, fetch_pc, mem_instr_d, mem_instr_done,
        input  fetch_ready, fetch_instr, mem_instr_signal, mem_instr_a
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, 8-byte lines refilled via one 64-bit fetch.
// Define ICACHE_STATS_EN to add the hit_count/miss_count counters.
module icache_direct #(
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic clear_signal,
    icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned TAG_WIDTH = 29 - INDEX_WIDTH;
    localparam int unsigned LINES     = 1 << INDEX_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_MISS
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [63:0]          data_q [LINES];

    logic        ready_q, ready_d;
    logic [31:0] instr_q, instr_d;
    logic        sig_q, sig_d;
    logic [31:0] addr_q, addr_d;
    logic        fill_en;
    logic        hit_acc;
    logic        miss_acc;

    logic [INDEX_WIDTH-1:0] pc_index;
    logic [TAG_WIDTH-1:0]   pc_tag;
    logic                   pc_word;
    logic                   hit;
    logic [31:0]            hit_word;
    logic [31:0]            fill_word;
    logic                   accept;
    logic                   unused_pc_bits;

    // The fetcher holds fetch_pc stable for the whole miss, so it also indexes the fill.
    assign pc_index       = bus.fetch_pc[2+INDEX_WIDTH:3];
    assign pc_tag         = bus.fetch_pc[31:3+INDEX_WIDTH];
    assign pc_word        = bus.fetch_pc[2];
    assign unused_pc_bits = ^bus.fetch_pc[1:0];

    assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign hit_word  = pc_word ? data_q[pc_index][63:32] : data_q[pc_index][31:0];
    assign fill_word = pc_word ? bus.mem_instr_d[63:32] : bus.mem_instr_d[31:0];

    // A cycle presenting fetch_ready never accepts, so a held pc is not answered twice.
    assign accept = bus.fetch_valid && !ready_q && !clear_signal;

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        instr_d  = instr_q;
        sig_d    = sig_q;
        addr_d   = addr_q;
        fill_en  = 1'b0;
        hit_acc  = 1'b0;
        miss_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        ready_d = 1'b1;
                        instr_d = hit_word;
                        hit_acc = 1'b1;
                    end else begin
                        sig_d    = 1'b1;
                        addr_d   = {bus.fetch_pc[31:3], 3'b000};
                        state_d  = S_MISS;
                        miss_acc = 1'b1;
                    end
                end
            end
            S_MISS: begin
                fill_en = bus.mem_instr_done;
                if (clear_signal) begin
                    sig_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (bus.mem_instr_done) begin
                    ready_d = 1'b1;
                    instr_d = fill_word;
                    sig_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                sig_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            instr_q <= '0;
            sig_q   <= 1'b0;
            addr_q  <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            ready_q <= ready_d;
            instr_q <= instr_d;
            sig_q   <= sig_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (rdy_in && fill_en) begin
            valid_q[pc_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill_en) begin
            tag_q[pc_index]  <= pc_tag;
            data_q[pc_index] <= bus.mem_instr_d;
        end
    end

    assign bus.fetch_ready      = ready_q;
    assign bus.fetch_instr      = instr_q;
    assign bus.mem_instr_signal = sig_q;
    assign bus.mem_instr_a      = addr_q;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in) begin
            if (hit_acc) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_acc) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: expected instructions queued at request, popped on fetch_ready.
module tb_icache_direct;
    localparam int unsigned INDEX_WIDTH = 4;
    localparam int unsigned MEM_LAT     = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear_signal;

    icache_direct_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_direct #(.INDEX_WIDTH(INDEX_WIDTH)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear_signal(clear_signal),
        .bus         (bus.slave)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned refills     = 0;
    int unsigned mem_wait    = 0;
    bit          mem_auto    = 1'b0;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'd0) return 32'h00A00093;
        if (a[31:2] == 30'd1) return 32'h00000013;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [63:0] line_of(input logic [31:0] a);
        return {mem_word({a[31:3], 3'b100}), mem_word({a[31:3], 3'b000})};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; all stimulus changes happen on the falling edge.
    task automatic tick();
        @(negedge clk_in);
        bus.mem_instr_done = 1'b0;
        if (mem_auto && bus.mem_instr_signal) begin
            if (mem_wait >= MEM_LAT) begin
                bus.mem_instr_done = 1'b1;
                bus.mem_instr_d    = line_of(bus.mem_instr_a);
                mem_wait           = 0;
                refills++;
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
    endtask

    task automatic take_reply(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_rdy"}, 64'(bus.fetch_ready), 64'd1);
        check(tag, 64'(bus.fetch_instr), 64'(e));
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] pc, input bit exp_miss);
        int unsigned r0;
        int unsigned lat;
        bit got;
        bit saw;
        r0  = refills;
        got = 1'b0;
        saw = 1'b0;
        lat = 0;
        exp_q.push_back(mem_word(pc));
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            if (bus.mem_instr_signal && !saw) begin
                saw = 1'b1;
                check({tag, "_addr"}, 64'(bus.mem_instr_a), 64'({pc[31:3], 3'b000}));
            end
            if (bus.fetch_ready) begin
                got = 1'b1;
                take_reply(tag);
                check({tag, "_sig_off"}, 64'(bus.mem_instr_signal), 64'd0);
            end
        end
        if (!got) begin
            void'(exp_q.pop_front());
            check({tag, "_timeout"}, 64'd0, 64'd1);
        end
        bus.fetch_valid = 1'b0;
        check({tag, "_req"}, 64'(saw), 64'(exp_miss));
        check({tag, "_refills"}, 64'(refills - r0), 64'(exp_miss));
        if (!exp_miss) check({tag, "_lat"}, 64'(lat), 64'd1);
        tick();
        check({tag, "_rdy_clr"}, 64'(bus.fetch_ready), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sig"}, 64'(bus.mem_instr_signal), 64'd0);
        check({tag, "_rdy"}, 64'(bus.fetch_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_in             = 1'b1;
        rdy_in             = 1'b1;
        clear_signal       = 1'b0;
        bus.fetch_valid    = 1'b0;
        bus.fetch_pc       = '0;
        bus.mem_instr_done = 1'b0;
        bus.mem_instr_d    = '0;
        tick();
        tick();
        check("rst_rdy",   64'(bus.fetch_ready), 64'd0);
        check("rst_instr", 64'(bus.fetch_instr), 64'd0);
        check("rst_sig",   64'(bus.mem_instr_signal), 64'd0);
        check("rst_addr",  64'(bus.mem_instr_a), 64'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hits",   64'(hit_count), 64'd0);
        check("rst_misses", 64'(miss_count), 64'd0);
`endif
        rst_in   = 1'b0;
        mem_auto = 1'b1;

        do_fetch("cold",     32'h0000_0000, 1'b1);
        do_fetch("hit_hi",   32'h0000_0004, 1'b0);
        do_fetch("hit_lo",   32'h0000_0000, 1'b0);
        do_fetch("conflict", 32'h0000_0080, 1'b1);
`ifdef ICACHE_STATS_EN
        check("stat_hits",   64'(hit_count), 64'd2);
        check("stat_misses", 64'(miss_count), 64'd2);
`endif
        do_fetch("refetch0", 32'h0000_0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            do_fetch("seq", 32'h0000_1000 + 32'(k) * 32'd4, (k % 2) == 0);
        end

        // Flush two cycles into a miss, no done.
        mem_auto        = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h0000_0100;
        tick();
        check("fl_sig",  64'(bus.mem_instr_signal), 64'd1);
        check("fl_addr", 64'(bus.mem_instr_a), 64'h100);
        tick();
        clear_signal    = 1'b1;
        bus.fetch_valid = 1'b0;
        tick();
        check_idle_outputs("fl_clr");
        clear_signal = 1'b0;
        tick();
        check_idle_outputs("fl_after");
        mem_auto = 1'b1;
        do_fetch("fl_refetch", 32'h0000_0100, 1'b1);

        // Flush coinciding with done: line kept, no reply.
        do_fetch("evict", 32'h0000_0000, 1'b1);
        mem_auto        = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h0000_0100;
        tick();
        check("fl2_sig", 64'(bus.mem_instr_signal), 64'd1);
        tick();
        bus.mem_instr_done = 1'b1;
        bus.mem_instr_d    = line_of(32'h0000_0100);
        clear_signal       = 1'b1;
        bus.fetch_valid    = 1'b0;
        tick();
        check_idle_outputs("fl2_clr");
        clear_signal = 1'b0;
        tick();
        check_idle_outputs("fl2_after");
        mem_auto = 1'b1;
        do_fetch("fl2_hit", 32'h0000_0100, 1'b0);

        // Stall mid-miss; done pulses during the stall must be ignored.
        mem_auto        = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h0000_0040;
        exp_q.push_back(mem_word(32'h0000_0040));
        tick();
        check("st_sig", 64'(bus.mem_instr_signal), 64'd1);
        tick();
        rdy_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            bus.mem_instr_done = 1'b1;
            bus.mem_instr_d    = ~line_of(32'h0000_0040);
            tick();
            check("st_hold_sig",  64'(bus.mem_instr_signal), 64'd1);
            check("st_hold_addr", 64'(bus.mem_instr_a), 64'h40);
            check("st_hold_rdy",  64'(bus.fetch_ready), 64'd0);
        end
        rdy_in             = 1'b1;
        bus.mem_instr_done = 1'b1;
        bus.mem_instr_d    = line_of(32'h0000_0040);
        tick();
        take_reply("st_reply");
        check("st_sig_off", 64'(bus.mem_instr_signal), 64'd0);
        bus.fetch_valid = 1'b0;
        tick();
        mem_auto = 1'b1;
        do_fetch("st_hit", 32'h0000_0044, 1'b0);

        // Reset mid-miss with a coincident done: request dropped, nothing filled.
        mem_auto        = 1'b0;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h0000_0048;
        tick();
        check("rm_sig", 64'(bus.mem_instr_signal), 64'd1);
        rst_in             = 1'b1;
        bus.mem_instr_done = 1'b1;
        bus.mem_instr_d    = line_of(32'h0000_0048);
        bus.fetch_valid    = 1'b0;
        tick();
        check_idle_outputs("rm_rst");
        check("rm_addr",  64'(bus.mem_instr_a), 64'd0);
        check("rm_instr", 64'(bus.fetch_instr), 64'd0);
        rst_in = 1'b0;
        tick();
        check_idle_outputs("rm_after");
        mem_auto = 1'b1;
        do_fetch("rm_0",  32'h0000_0000, 1'b1);
        do_fetch("rm_48", 32'h0000_0048, 1'b1);
`ifdef ICACHE_STATS_EN
        check("rm_hits",   64'(hit_count), 64'd0);
        check("rm_misses", 64'(miss_count), 64'd2);
`endif
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
